// File: rtl/mux_scan_seq_if.sv
// Channel-scan multiplexer bus: packed channel data and controls in,
// registered selection results out.
interface mux_scan_seq_if #(
  parameter int W  = 1,
  parameter int N  = 8,
  parameter int SW = 3,
  parameter int DW = 4
);
  logic [N*W-1:0] d;
  logic [SW-1:0]  s;
  logic           mode;
  logic [N-1:0]   en_mask;
  logic [DW-1:0]  dwell;
  logic [W-1:0]   o;
  logic [SW-1:0]  ch;
  logic           valid;
  logic           wrap;

  // Stimulus side: drives data and controls, observes the selection.
  modport master (
    output d, s, mode, en_mask, dwell,
    input  o, ch, valid, wrap
  );

  // Multiplexer side: consumes data and controls, produces the selection.
  modport slave (
    input  d, s, mode, en_mask, dwell,
    output o, ch, valid, wrap
  );
endinterface

// File: rtl/mux_scan_seq.sv
// Registered N:1 multiplexer with a manual mode (channel chosen by s) and a
// scan mode that walks the enabled channels in ascending order, holding each
// for dwell+1 cycles and pulsing wrap when the pass restarts at the lowest.
//
// Handshake: there is no valid/ready flow control. valid is a qualifier only:
// it is high exactly when o carries the slice of a legal channel selected in
// the current mode; o, ch, valid and wrap always change together on one edge.
module mux_scan_seq #(
  parameter int W  = 1,
  parameter int N  = 8,
  parameter int SW = 3,
  parameter int DW = 4
) (
  input  logic           clk,
  input  logic           rst,
  mux_scan_seq_if.slave  bus,
  output logic [1:0]     dbg_state_o,
  output logic [DW-1:0]  dbg_cnt_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAN  = 2'd1,
    SCAN = 2'd2
  } state_t;

  state_t         state_q;
  logic [W-1:0]   o_q;
  logic [SW-1:0]  ch_q;
  logic           valid_q;
  logic           wrap_q;
  logic [DW-1:0]  cnt_q;

  // Channel-search results for the current mask and channel.
  logic           any_en;
  logic [SW-1:0]  first_ch;
  logic [SW-1:0]  above_ch;
  logic           above_found;
  logic [SW-1:0]  next_ch_d;
  logic           next_wrap_d;
  logic           cur_en;
  logic           s_legal;
  logic [W-1:0]   d_s;
  logic [W-1:0]   d_first;
  logic [W-1:0]   d_next;
  logic [W-1:0]   d_cur;

  // Slice of the packed data for a channel index; indices >= N read as zero.
  function automatic logic [W-1:0] slice_of(input logic [N*W-1:0] dv,
                                             input logic [SW-1:0]  idx);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) begin
      if (int'(idx) == i) r = dv[i*W +: W];
    end
    return r;
  endfunction

  // Find the lowest enabled channel and the next enabled channel above ch_q;
  // when nothing is enabled above ch_q the scan wraps to the lowest.
  always_comb begin
    any_en      = |bus.en_mask;
    first_ch    = '0;
    above_ch    = '0;
    above_found = 1'b0;
    cur_en      = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (bus.en_mask[i]) first_ch = SW'(i);
      if (bus.en_mask[i] && (i > int'(ch_q))) begin
        above_found = 1'b1;
        above_ch    = SW'(i);
      end
      if (int'(ch_q) == i) cur_en = bus.en_mask[i];
    end
    next_ch_d   = above_found ? above_ch : first_ch;
    next_wrap_d = ~above_found;
    s_legal     = (int'(bus.s) < N);
    d_s         = slice_of(bus.d, bus.s);
    d_first     = slice_of(bus.d, first_ch);
    d_next      = slice_of(bus.d, next_ch_d);
    d_cur       = slice_of(bus.d, ch_q);
  end

  // Mode FSM with registered outputs; reset wins over every other input.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      o_q     <= '0;
      ch_q    <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          // Leave IDLE only; outputs keep their reset values on this edge.
          state_q <= bus.mode ? SCAN : MAN;
        end
        MAN, SCAN: begin
          if (!bus.mode) begin
            state_q <= MAN;
            ch_q    <= bus.s;
            o_q     <= s_legal ? d_s : '0;
            valid_q <= s_legal;
            wrap_q  <= 1'b0;
            cnt_q   <= '0;
          end else if ((state_q != SCAN) || !valid_q) begin
            // Scan entry, first scan edge after IDLE, or recovery from an
            // empty mask: start from the lowest enabled channel.
            state_q <= SCAN;
            wrap_q  <= 1'b0;
            cnt_q   <= '0;
            if (any_en) begin
              ch_q    <= first_ch;
              o_q     <= d_first;
              valid_q <= 1'b1;
            end else begin
              valid_q <= 1'b0;
            end
          end else if (!any_en) begin
            // Nothing to scan: hold o/ch, drop valid, park the counter.
            valid_q <= 1'b0;
            wrap_q  <= 1'b0;
            cnt_q   <= '0;
          end else if (!cur_en || (cnt_q >= bus.dwell)) begin
            // Dwell expired, dwell lowered below the count, or the current
            // channel was disabled: move on to the next enabled channel.
            ch_q    <= next_ch_d;
            o_q     <= d_next;
            valid_q <= 1'b1;
            wrap_q  <= next_wrap_d;
            cnt_q   <= '0;
          end else begin
            o_q     <= d_cur;
            valid_q <= 1'b1;
            wrap_q  <= 1'b0;
            cnt_q   <= cnt_q + DW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.o       = o_q;
  assign bus.ch      = ch_q;
  assign bus.valid   = valid_q;
  assign bus.wrap    = wrap_q;
  assign dbg_state_o = state_q;
  assign dbg_cnt_o   = cnt_q;

endmodule

// File: doc/mux_scan_seq.md
MUX_SCAN_SEQ -- requirements
Module: mux_scan_seq

Interface
REQ-001 SHALL have parameter W, default 1: data width of each channel in bits.
REQ-002 SHALL have parameter N, default 8: number of input channels, minimum 2.
REQ-003 SHALL have parameter SW, default 3: select and channel-index width, with 2**SW >= N.
REQ-004 SHALL have parameter DW, default 4: width of the dwell input.
REQ-005 SHALL have port clk  input  1: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst  input  1: reset, synchronous and active-high.
REQ-007 SHALL have port d  input  N*W: packed channel data; channel i occupies bits [i*W+W-1 : i*W].
REQ-008 SHALL have port s  input  SW: channel select, used in manual mode.
REQ-009 SHALL have port mode  input  1: 0 selects manual mode, 1 selects scan mode.
REQ-010 SHALL have port en_mask  input  N: scan enable per channel; bit i set means channel i takes part in the scan.
REQ-011 SHALL have port dwell  input  DW: channel hold time in scan mode, equal to dwell+1 cycles.
REQ-012 SHALL have port o  output  W: registered output data.
REQ-013 SHALL have port ch  output  SW: registered index of the channel currently presented on o.
REQ-014 SHALL have port valid  output  1: high when o holds data from a legal, selected channel.
REQ-015 SHALL have port wrap  output  1: one-cycle pulse when a scan pass completes.

Function
REQ-016 SHALL implement an FSM with three states: IDLE, MAN and SCAN.
REQ-017 SHALL move from IDLE to MAN (mode=0) or SCAN (mode=1) on the first edge after rst is deasserted; o, ch, valid and wrap keep their reset values during that edge.
REQ-018 SHALL, in MAN or SCAN, go to the state given by mode on the next edge after mode changes; the FSM never returns to IDLE except through rst.
REQ-019 SHALL update o, ch and valid together on each edge in MAN and SCAN; o equals the d slice of the channel loaded into ch, sampled at that same edge (one-cycle latency).
REQ-020 SHALL, in MAN with s < N, load ch <= s and o <= d[s] and set valid=1.
REQ-021 SHALL, in MAN with s >= N, load o <= 0 and ch <= s and set valid=0.
REQ-022 SHALL, on entry to SCAN, load the lowest-indexed enabled channel, clear the dwell counter and set valid=1.
REQ-023 SHALL, in SCAN, refresh o from d[ch] on every edge, so a live data change appears one cycle later.
REQ-024 SHALL, in SCAN, advance to the next higher enabled channel, clear the dwell counter and refresh o when the dwell counter equals dwell; otherwise the counter increments by 1.
REQ-025 SHALL wrap from the highest enabled channel to the lowest enabled channel and pulse wrap=1 for exactly the cycle in which the wrapped channel is presented.
REQ-026 SHALL, with exactly one enabled channel, re-present that channel every dwell+1 cycles and pulse wrap each time.
REQ-027 SHALL, with en_mask all zero in SCAN, hold o and ch, set valid=0, not pulse wrap, and hold the dwell counter at 0.
REQ-028 SHALL, when en_mask becomes nonzero again after all-zero, restart the scan from the lowest enabled channel on the next edge.
REQ-029 SHALL, when the channel in ch is disabled mid-dwell, advance to the next enabled channel on the next edge, whatever the counter value.
REQ-030 SHALL sample dwell on every edge; a reduction below the current count causes an advance on the next edge.
REQ-031 SHALL use only channel indices below N; en_mask bits never map beyond N-1.

Reset
REQ-032 SHALL, with rst=1 at an edge in any state (including mid-dwell), set state=IDLE, o=0, ch=0, valid=0, wrap=0 and dwell counter=0.
REQ-033 SHALL give rst priority over every other input.

Verification
REQ-034 SHALL cover manual sweep: W=1, N=8, d=8'b01010101, mode=0, s stepping 0..7 one step per 10 cycles -> o follows 1,0,1,0,1,0,1,0 one cycle after each s change, valid=1 throughout.
REQ-035 SHALL cover scan order and dwell: en_mask=8'b10010110, dwell=2 -> ch sequence 1,2,4,7,1 at 3 cycles each, with wrap high only in the first cycle at which ch returns to 1.
REQ-036 SHALL cover single enabled channel and empty mask: en_mask=8'b00001000, dwell=0 -> ch=3 every cycle with wrap=1 every cycle; then en_mask=0 -> valid=0 and o/ch held; then en_mask=8'b00100000 -> ch=5 with valid=1 one edge later.
REQ-037 SHALL cover disabling the current channel: ch=4 at count 1, dwell=5, clear en_mask[4] -> next edge gives ch=the next enabled index and counter=0.
REQ-038 SHALL cover reset mid-scan: rst=1 for one edge at ch=6 -> o=0, ch=0, valid=0, wrap=0; after rst=0 there is one IDLE cycle, then the scan restarts at the lowest enabled channel.
REQ-039 SHALL cover illegal manual select: N=6, SW=3, mode=0, s=7 -> o=0, valid=0; then s=2 -> o=d[2], valid=1 one cycle later.
